mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pkg.sv | 29 ++
 rtl/mem_wb_if.sv | 41 ++++
 rtl/mem_wb_load_align.sv | 56 +++++
 rtl/mem_wb_pipe.sv | 98 +++++++++
 tb/tb_mem_wb_pipe.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared load-type encodings and reset constants for the MEM/WB stage
package mem_wb_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6,
    LT_RSV = 3'd7
  } load_type_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Little-endian byte lane select within a 32-bit word.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - MEM/WB stage handshake and data bundle with upstream/downstream modports
interface mem_wb_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic            flush;
  logic [DW-1:0]   pc_in;
  logic [DW-1:0]   alu_in;
  logic [DW-1:0]   rt_in;
  logic [RW-1:0]   wreg_in;
  logic            reg_write_in;
  logic            mem_to_reg_in;
  logic [2:0]      load_type;
  logic            hilo_write_in;
  logic [2*DW-1:0] hilo_in;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   pc_out;
  logic [DW-1:0]   result;
  logic [RW-1:0]   wreg_out;
  logic            reg_write_out;
  logic            hilo_write_out;
  logic [2*DW-1:0] hilo_out;

  modport slave (
    input  in_valid, out_ready, flush, pc_in, alu_in, rt_in, wreg_in, reg_write_in,
           mem_to_reg_in, load_type, hilo_write_in, hilo_in, mem_rdata,
    output in_ready, out_valid, pc_out, result, wreg_out, reg_write_out,
           hilo_write_out, hilo_out
  );

  modport master (
    output in_valid, out_ready, flush, pc_in, alu_in, rt_in, wreg_in, reg_write_in,
           mem_to_reg_in, load_type, hilo_write_in, hilo_in, mem_rdata,
    input  in_ready, out_valid, pc_out, result, wreg_out, reg_write_out,
           hilo_write_out, hilo_out
  );
endinterface

// File: rtl/mem_wb_load_align.sv
// rtl/mem_wb_load_align.sv - combinational load data formatter (LWL/LWR under MEM_WB_UNALIGNED_EN)
module load_align
  import mem_wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    type_i,
  input  logic [1:0]    offset_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] rt_i,
  output logic [DW-1:0] word_o
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = pick_byte(rdata_i[31:0], offset_i);
  // offset[0] is ignored for halves; misaligned halves never reach this stage.
  assign h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    word_o = rdata_i;
    case (load_type_e'(type_i))
      LT_LB:  word_o = {{(DW-8){b[7]}}, b};
      LT_LBU: word_o = {{(DW-8){1'b0}}, b};
      LT_LH:  word_o = {{(DW-16){h[15]}}, h};
      LT_LHU: word_o = {{(DW-16){1'b0}}, h};
`ifdef MEM_WB_UNALIGNED_EN
      LT_LWL: begin
        case (offset_i)
          2'd0:    word_o = {rdata_i[7:0],  rt_i[23:0]};
          2'd1:    word_o = {rdata_i[15:0], rt_i[15:0]};
          2'd2:    word_o = {rdata_i[23:0], rt_i[7:0]};
          default: word_o = rdata_i;
        endcase
      end
      LT_LWR: begin
        case (offset_i)
          2'd0:    word_o = rdata_i;
          2'd1:    word_o = {rt_i[31:24], rdata_i[31:8]};
          2'd2:    word_o = {rt_i[31:16], rdata_i[31:16]};
          default: word_o = {rt_i[31:8],  rdata_i[31:24]};
        endcase
      end
`endif
      default: word_o = rdata_i;
    endcase
  end

`ifdef MEM_WB_UNALIGNED_EN
`else
  logic unused_rt;
  assign unused_rt = ^rt_i;
`endif

endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB single-entry register slice; MEM_WB_UNALIGNED_EN enables LWL/LWR
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            RW       = 5,
  parameter logic [DW-1:0] RESET_PC = DW'(RESET_PC_DEFAULT)
) (
  input logic   clk,
  input logic   resetn,
  mem_wb_if.slave bus
);

  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   pc_q;
  logic [DW-1:0]   alu_q;
  logic [RW-1:0]   wreg_q;
  logic            reg_write_q;
  logic            mem_to_reg_q;
  logic [2:0]      load_type_q;
  logic            hilo_write_q;
  logic [2*DW-1:0] hilo_q;
  logic [DW-1:0]   rt_q;
  logic [DW-1:0]   aligned;
  logic            in_ready;
  logic            capture;

  assign in_ready = ~resetn | ~out_valid_q | bus.out_ready;
  assign capture  = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush)
      out_valid_d = 1'b0;
    else if (capture)
      out_valid_d = 1'b1;
    else if (bus.out_ready)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      pc_q         <= RESET_PC;
      alu_q        <= '0;
      wreg_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= '0;
      hilo_write_q <= 1'b0;
      hilo_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (capture) begin
        pc_q         <= bus.pc_in;
        alu_q        <= bus.alu_in;
        wreg_q       <= bus.wreg_in;
        reg_write_q  <= bus.reg_write_in;
        mem_to_reg_q <= bus.mem_to_reg_in;
        load_type_q  <= bus.load_type;
        hilo_write_q <= bus.hilo_write_in;
        hilo_q       <= bus.hilo_in;
      end
    end
  end

`ifdef MEM_WB_UNALIGNED_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      rt_q <= '0;
    else if (capture)
      rt_q <= bus.rt_in;
  end
`else
  // The old rt value only matters for partial-word merges.
  assign rt_q = '0;
  logic unused_rt_in;
  assign unused_rt_in = ^bus.rt_in;
`endif

  load_align #(.DW(DW)) u_align (
    .type_i   (load_type_q),
    .offset_i (alu_q[1:0]),
    .rdata_i  (bus.mem_rdata),
    .rt_i     (rt_q),
    .word_o   (aligned)
  );

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.pc_out         = pc_q;
  assign bus.result         = mem_to_reg_q ? aligned : alu_q;
  assign bus.wreg_out       = wreg_q;
  assign bus.reg_write_out  = reg_write_q & out_valid_q;
  assign bus.hilo_write_out = hilo_write_q & out_valid_q;
  assign bus.hilo_out       = hilo_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - self-checking bench for mem_wb_pipe (vector table plus scoreboard)
module tb_mem_wb_pipe;
  import mem_wb_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_wb_if #(.DW(32), .RW(5)) bus ();

  mem_wb_pipe #(.DW(32), .RW(5), .RESET_PC(32'hBFC0_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc, alu, rt, rdata, exp;
    logic [4:0]  wreg;
    logic        rw, m2r, hw;
    logic [2:0]  lt;
    logic [63:0] hilo;
  } txn_t;

  typedef struct {
    logic [2:0]  lt;
    logic        m2r;
    logic [31:0] alu, rdata, rt, exp;
  } vec_t;

  txn_t q[$];
  txn_t cur;
  vec_t vecs[16];
  logic c_valid, c_ready, c_flush, c_resetn;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input int i, input vec_t v);
    txn_t t;
    logic [31:0] ii;
    ii     = i;
    t.pc   = 32'h0040_0000 + (ii << 2);
    t.alu  = v.alu;
    t.rt   = v.rt;
    t.rdata= v.rdata;
    t.exp  = v.exp;
    t.wreg = ii[4:0];
    t.rw   = ii[0];
    t.hw   = ii[1];
    t.m2r  = v.m2r;
    t.lt   = v.lt;
    t.hilo = {ii, ~ii};
    return t;
  endfunction

  // One cycle: drive at negedge, check 1ns later, then advance the model.
  task automatic step();
    logic exp_ready;
    @(negedge clk);
    resetn            = c_resetn;
    bus.in_valid      = c_valid;
    bus.out_ready     = c_ready;
    bus.flush         = c_flush;
    bus.pc_in         = cur.pc;
    bus.alu_in        = cur.alu;
    bus.rt_in         = cur.rt;
    bus.wreg_in       = cur.wreg;
    bus.reg_write_in  = cur.rw;
    bus.mem_to_reg_in = cur.m2r;
    bus.load_type     = cur.lt;
    bus.hilo_write_in = cur.hw;
    bus.hilo_in       = cur.hilo;
    bus.mem_rdata     = (q.size() != 0) ? q[0].rdata : 32'h0;
    #1;
    exp_ready = !c_resetn || (q.size() == 0) || c_ready;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    if (q.size() != 0) begin
      chk("pc_out", 64'(bus.pc_out), 64'(q[0].pc));
      chk("result", 64'(bus.result), 64'(q[0].exp));
      chk("wreg_out", 64'(bus.wreg_out), 64'(q[0].wreg));
      chk("reg_write_out", 64'(bus.reg_write_out), 64'(q[0].rw));
      chk("hilo_write_out", 64'(bus.hilo_write_out), 64'(q[0].hw));
      chk("hilo_out", bus.hilo_out, q[0].hilo);
    end else begin
      chk("bubble_reg_write", 64'(bus.reg_write_out), 64'd0);
      chk("bubble_hilo_write", 64'(bus.hilo_write_out), 64'd0);
    end
    if (!c_resetn || c_flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && c_ready) void'(q.pop_front());
      if (c_valid && exp_ready) q.push_back(cur);
    end
  endtask

  task automatic drain();
    int n = 0;
    c_valid = 1'b0;
    c_ready = 1'b1;
    c_flush = 1'b0;
    while (q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF};
    vecs[1]  = '{3'd1, 1'b1, 32'h0000_1003, 32'h80FF_1234, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{3'd2, 1'b1, 32'h0000_1003, 32'h80FF_1234, 32'h0, 32'h0000_0080};
    vecs[3]  = '{3'd1, 1'b1, 32'h0000_1000, 32'h80FF_1234, 32'h0, 32'h0000_0034};
    vecs[4]  = '{3'd1, 1'b1, 32'h0000_1002, 32'h80FF_1234, 32'h0, 32'hFFFF_FFFF};
    vecs[5]  = '{3'd2, 1'b1, 32'h0000_1001, 32'h80FF_1234, 32'h0, 32'h0000_0012};
    vecs[6]  = '{3'd3, 1'b1, 32'h0000_2002, 32'h8001_7FFF, 32'h0, 32'hFFFF_8001};
    vecs[7]  = '{3'd4, 1'b1, 32'h0000_2002, 32'h8001_7FFF, 32'h0, 32'h0000_8001};
    vecs[8]  = '{3'd3, 1'b1, 32'h0000_2000, 32'h8001_7FFF, 32'h0, 32'h0000_7FFF};
    vecs[9]  = '{3'd3, 1'b1, 32'h0000_2003, 32'h8001_7FFF, 32'h0, 32'hFFFF_8001};
    vecs[10] = '{3'd1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678};
    vecs[11] = '{3'd7, 1'b1, 32'h0000_3001, 32'hCAFE_BABE, 32'h0, 32'hCAFE_BABE};
`ifdef MEM_WB_UNALIGNED_EN
    vecs[12] = '{3'd5, 1'b1, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 32'hCCDD_3344};
    vecs[13] = '{3'd6, 1'b1, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 32'h11AA_BBCC};
    vecs[14] = '{3'd5, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 32'h1122_3344, 32'hDD22_3344};
    vecs[15] = '{3'd6, 1'b1, 32'h0000_0103, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_33AA};
`else
    vecs[12] = '{3'd5, 1'b1, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
    vecs[13] = '{3'd6, 1'b1, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
    vecs[14] = '{3'd5, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
    vecs[15] = '{3'd6, 1'b1, 32'h0000_0103, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CCDD};
`endif

    cur = mk(0, vecs[0]);
    c_valid = 1'b0; c_ready = 1'b0; c_flush = 1'b0; c_resetn = 1'b0;
    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    bus.pc_in = '0; bus.alu_in = '0; bus.rt_in = '0; bus.wreg_in = '0;
    bus.reg_write_in = 1'b0; bus.mem_to_reg_in = 1'b0; bus.load_type = '0;
    bus.hilo_write_in = 1'b0; bus.hilo_in = '0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("in_ready_in_reset", 64'(bus.in_ready), 64'd1);

    // Reset state
    c_resetn = 1'b1;
    step();
    chk("reset_pc_out", 64'(bus.pc_out), 64'hBFC0_0000);
    chk("reset_result", 64'(bus.result), 64'd0);

    // Vector table, back-to-back with out_ready held high
    c_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cur = mk(i, vecs[i]);
      c_valid = 1'b1;
      step();
    end
    drain();

    // Stall for three cycles with a second instruction waiting, then release
    c_ready = 1'b0;
    cur = mk(20, vecs[1]); cur.rw = 1'b1; c_valid = 1'b1;
    step();
    cur = mk(21, vecs[6]);
    repeat (3) step();
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    c_ready = 1'b1;
    step();
    cur = mk(22, vecs[0]);
    step();
    drain();

    // Flush coincident with in_valid discards both held and incoming
    c_ready = 1'b0;
    cur = mk(23, vecs[2]); cur.rw = 1'b1; c_valid = 1'b1;
    step();
    cur = mk(25, vecs[3]); cur.rw = 1'b1; c_flush = 1'b1;
    step();
    c_flush = 1'b0; c_valid = 1'b0;
    step();
    chk("flush_reg_write", 64'(bus.reg_write_out), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);

    // Reset during a stall drops the held instruction
    c_ready = 1'b0;
    cur = mk(26, vecs[7]); cur.hw = 1'b1; c_valid = 1'b1;
    step();
    step();
    c_resetn = 1'b0;
    step();
    c_resetn = 1'b1; c_valid = 1'b0;
    step();
    chk("rst_stall_pc_out", 64'(bus.pc_out), 64'hBFC0_0000);
    chk("rst_stall_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_stall_hilo_write", 64'(bus.hilo_write_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
